// File: rtl/servant_uart_rx.sv
// 8N1 UART receiver for the servant SoC serial pin: synchronizes the line,
// samples each bit at mid-period and reports good bytes and framing errors.
module servant_uart_rx #(
  parameter int CLKS_PER_BIT = 694
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic        q,
  output logic [7:0]  rx_data,
  output logic        rx_vld,
  output logic        rx_ferr,
  output logic        rx_busy,
  output logic [31:0] rx_cnt
);

  localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q, qs_q;
  logic [15:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        vld_q, vld_d;
  logic        ferr_q, ferr_d;
  logic [31:0] cnt_q, cnt_d;
  logic        sample;

  assign sample = (bit_cnt_q == 16'd0);

  // State and datapath registers; the synchronizer idles high like the line.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      sync1_q   <= 1'b1;
      qs_q      <= 1'b1;
      state_q   <= S_IDLE;
      bit_cnt_q <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      vld_q     <= 1'b0;
      ferr_q    <= 1'b0;
      cnt_q     <= 32'd0;
    end else begin
      sync1_q   <= q;
      qs_q      <= sync1_q;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      ferr_q    <= ferr_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    case (state_q)
      S_IDLE: begin
        if (!qs_q) begin
          state_d   = S_START;
          bit_cnt_d = HALF_LOAD;
        end
      end
      S_START: begin
        if (sample) begin
          bit_cnt_d = FULL_LOAD;
          bit_idx_d = 3'd0;
          state_d   = qs_q ? S_IDLE : S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (sample) begin
          // Right shift: the first data bit ends up in bit 0.
          shift_d   = {qs_q, shift_q[7:1]};
          bit_cnt_d = FULL_LOAD;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (sample) state_d = qs_q ? S_IDLE : S_BREAK;
        else        bit_cnt_d = bit_cnt_q - 16'd1;
      end
      S_BREAK: begin
        if (qs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_busy = (state_q != S_IDLE);
    vld_d   = (state_q == S_STOP) && sample && qs_q;
    ferr_d  = (state_q == S_STOP) && sample && !qs_q;
    data_d  = vld_d ? shift_q : data_q;
    cnt_d   = vld_d ? cnt_q + 32'd1 : cnt_q;
  end

  assign rx_data = data_q;
  assign rx_vld  = vld_q;
  assign rx_ferr = ferr_q;
  assign rx_cnt  = cnt_q;

endmodule

// File: tb/tb_servant_uart_rx.sv
// Bench for servant_uart_rx at 8 clocks per bit: stimulus queues expected
// events, a monitor pops and compares them whenever rx_vld or rx_ferr fires.
module tb_servant_uart_rx;

  localparam int C = 8;

  logic        wb_clk;
  logic        wb_rst_n;
  logic        q;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic        rx_ferr;
  logic        rx_busy;
  logic [31:0] rx_cnt;

  servant_uart_rx #(.CLKS_PER_BIT(C)) dut (
    .wb_clk  (wb_clk),
    .wb_rst_n(wb_rst_n),
    .q       (q),
    .rx_data (rx_data),
    .rx_vld  (rx_vld),
    .rx_ferr (rx_ferr),
    .rx_busy (rx_busy),
    .rx_cnt  (rx_cnt)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  typedef struct {
    bit          is_ferr;
    logic [7:0]  data;
    logic [31:0] cnt;
    int          gap;
  } evt_t;

  evt_t        sb_q[$];
  int          n_total  = 0;
  int          n_passed = 0;
  int          n_events = 0;
  int          cyc      = 0;
  int          last_cyc = 0;
  logic [7:0]  last_good = 8'h00;
  logic [31:0] exp_cnt   = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req)
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    else
      n_passed++;
  endtask

  task automatic expect_good(input logic [7:0] b, input int gap);
    evt_t e;
    exp_cnt   = exp_cnt + 32'd1;
    last_good = b;
    e.is_ferr = 1'b0;
    e.data    = b;
    e.cnt     = exp_cnt;
    e.gap     = gap;
    sb_q.push_back(e);
  endtask

  task automatic expect_ferr();
    evt_t e;
    e.is_ferr = 1'b1;
    e.data    = last_good;
    e.cnt     = exp_cnt;
    e.gap     = 0;
    sb_q.push_back(e);
  endtask

  // Drives one 8N1 frame starting at a falling edge; the line is left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
    q = 1'b0;
    repeat (C) @(negedge wb_clk);
    for (int i = 0; i < 8; i++) begin
      q = b[i];
      repeat (C) @(negedge wb_clk);
    end
    q = stop_lvl;
    repeat (C) @(negedge wb_clk);
  endtask

  // Monitor: every output event must match the head of the scoreboard.
  initial begin
    evt_t e;
    forever begin
      @(negedge wb_clk);
      cyc++;
      if (rx_vld === 1'b1 || rx_ferr === 1'b1) begin
        n_events++;
        chk("vld_ferr_exclusive", {31'd0, rx_vld & rx_ferr}, 32'd0);
        if (sb_q.size() == 0) begin
          chk("unexpected_event", {30'd0, rx_vld, rx_ferr}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("event_kind_ferr", {31'd0, rx_ferr}, {31'd0, e.is_ferr});
          chk("event_rx_data", {24'd0, rx_data}, {24'd0, e.data});
          chk("event_rx_cnt", rx_cnt, e.cnt);
          if (e.gap > 0) chk("event_gap", cyc - last_cyc, e.gap);
          if (!e.is_ferr) chk("busy_after_vld", {31'd0, rx_busy}, 32'd0);
          $display("event %0d: %s data=0x%02h cnt=%0d cycle=%0d", n_events,
                   e.is_ferr ? "ferr" : "vld", rx_data, rx_cnt, cyc);
        end
        last_cyc = cyc;
      end
    end
  end

  initial begin
    wb_rst_n = 1'b0;
    q        = 1'b1;
    repeat (5) @(negedge wb_clk);
    chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
    chk("reset_rx_cnt", rx_cnt, 32'd0);
    chk("reset_rx_vld", {31'd0, rx_vld}, 32'd0);
    chk("reset_rx_ferr", {31'd0, rx_ferr}, 32'd0);
    chk("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    wb_rst_n = 1'b1;
    repeat (3) @(negedge wb_clk);

    // Single good byte
    expect_good(8'h55, 0);
    send_frame(8'h55, 1'b1);
    q = 1'b1;
    repeat (3 * C) @(negedge wb_clk);

    // Back-to-back frames with no idle time: events exactly one frame apart
    expect_good(8'h00, 0);
    expect_good(8'hFF, 10 * C);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    q = 1'b1;
    repeat (3 * C) @(negedge wb_clk);

    // Two-cycle glitch must be rejected at the start-bit sample
    q = 1'b0;
    repeat (2) @(negedge wb_clk);
    q = 1'b1;
    repeat (6) @(negedge wb_clk);
    chk("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
    chk("glitch_rx_cnt", rx_cnt, exp_cnt);
    repeat (2 * C) @(negedge wb_clk);

    // Framing error followed by a long break, then a good byte
    expect_ferr();
    send_frame(8'hA5, 1'b0);
    repeat (200) @(negedge wb_clk);
    chk("break_rx_data_held", {24'd0, rx_data}, {24'd0, last_good});
    chk("break_busy_high", {31'd0, rx_busy}, 32'd1);
    q = 1'b1;
    repeat (2 * C) @(negedge wb_clk);
    expect_good(8'h3C, 0);
    send_frame(8'h3C, 1'b1);
    q = 1'b1;
    repeat (3 * C) @(negedge wb_clk);

    // Reset in the middle of data bit 4 abandons the frame
    q = 1'b0;
    repeat (C) @(negedge wb_clk);
    for (int i = 0; i < 4; i++) begin
      q = i[0];
      repeat (C) @(negedge wb_clk);
    end
    q = 1'b1;
    repeat (C / 2) @(negedge wb_clk);
    wb_rst_n = 1'b0;
    repeat (3) @(negedge wb_clk);
    chk("midreset_rx_data", {24'd0, rx_data}, 32'd0);
    chk("midreset_rx_cnt", rx_cnt, 32'd0);
    chk("midreset_rx_busy", {31'd0, rx_busy}, 32'd0);
    chk("midreset_rx_vld", {31'd0, rx_vld}, 32'd0);
    wb_rst_n  = 1'b1;
    exp_cnt   = 32'd0;
    last_good = 8'h00;
    repeat (2 * C) @(negedge wb_clk);
    expect_good(8'h81, 0);
    send_frame(8'h81, 1'b1);
    q = 1'b1;
    repeat (3 * C) @(negedge wb_clk);

    chk("final_rx_data", {24'd0, rx_data}, 32'h81);
    chk("final_rx_cnt", rx_cnt, 32'd1);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    chk("event_count", n_events, 32'd6);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
